topk_feeder: RTL and testbench

//  Source side of the top-k selection stream. Accepts one token's expert scores as

---
 rtl/topk_feeder_if.sv | 28 ++
 rtl/topk_feeder.sv | 134 +++++++++++++
 tb/tb_topk_feeder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/topk_feeder_if.sv
// Score stream bundle between the gating matmul, the feeder and the top-k selector.
// master: vector source / selector side; slave: topk_feeder.
interface topk_feeder_if #(
  parameter int LANES   = 16,
  parameter int SCORE_W = 16,
  parameter int ID_W    = 7
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*SCORE_W-1:0] in_scores;
  logic                     tk_valid;
  logic [SCORE_W-1:0]       tk_score;
  logic [ID_W-1:0]          tk_id;
  logic                     tk_done;
  logic                     busy;

  modport master (
    output in_valid, in_scores,
    input  in_ready, tk_valid, tk_score,
    input  tk_id, tk_done, busy
  );

  modport slave (
    input  in_valid, in_scores,
    output in_ready, tk_valid, tk_score,
    output tk_id, tk_done, busy
  );
endinterface

// File: rtl/topk_feeder.sv
// topk_feeder: serialises a token's LANES-wide score vectors into one score
// per cycle (with expert id) for the top-k selector, then holds tk_done.
// Ports: clk, rst (async, active-high), bus (slave):
//   in_valid/in_ready/in_scores  vector input handshake
//   tk_valid/tk_score/tk_id      serial score stream (registered)
//   tk_done                      read-out window (registered)
//   busy                         token in progress
module topk_feeder #(
  parameter int NUM_EXPERTS = 128,
  parameter int LANES       = 16,
  parameter int SCORE_W     = 16,
  parameter int ID_W        = 7,
  parameter int DONE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  topk_feeder_if.slave bus
);

  localparam int BEATS = NUM_EXPERTS / LANES;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW =
    (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SERIAL,
    DONE
  } state_t;

  state_t                   state;
  logic [BW-1:0]            beat_cnt;
  logic [LW-1:0]            lane;
  logic [DW-1:0]            done_cnt;
  logic [LANES*SCORE_W-1:0] vec_q;

  logic                     tk_valid_q;
  logic [SCORE_W-1:0]       tk_score_q;
  logic [ID_W-1:0]          tk_id_q;
  logic                     tk_done_q;

  logic                     rdy;
  logic                     accept;
  logic                     last_lane;
  logic                     final_beat;
  logic [LW-1:0]            lane_nx;
  logic [ID_W-1:0]          base_id;

  assign last_lane  = (lane == LW'(LANES - 1));
  assign final_beat = (beat_cnt == BW'(BEATS - 1));
  assign lane_nx    = lane + LW'(1);
  assign base_id    = ID_W'(beat_cnt) * ID_W'(LANES);
  assign accept     = bus.in_valid && rdy;

  // Ready in IDLE, or on the last lane of a non-final beat so the
  // next vector follows without a bubble.
  always_comb begin
    rdy = 1'b0;
    unique case (state)
      IDLE:    rdy = 1'b1;
      SERIAL:  rdy = last_lane && !final_beat;
      default: rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      lane       <= '0;
      done_cnt   <= '0;
      vec_q      <= '0;
      tk_valid_q <= 1'b0;
      tk_score_q <= '0;
      tk_id_q    <= '0;
      tk_done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            vec_q      <= bus.in_scores;
            lane       <= '0;
            tk_valid_q <= 1'b1;
            tk_score_q <= bus.in_scores[SCORE_W-1:0];
            tk_id_q    <= base_id;
            state      <= SERIAL;
          end
        end
        SERIAL: begin
          if (!last_lane) begin
            lane       <= lane_nx;
            tk_score_q <=
              vec_q[int'(lane_nx)*SCORE_W +: SCORE_W];
            tk_id_q    <= tk_id_q + ID_W'(1);
          end else if (final_beat) begin
            beat_cnt   <= '0;
            tk_valid_q <= 1'b0;
            tk_done_q  <= 1'b1;
            done_cnt   <= '0;
            state      <= DONE;
          end else if (accept) begin
            beat_cnt   <= beat_cnt + BW'(1);
            vec_q      <= bus.in_scores;
            lane       <= '0;
            tk_score_q <= bus.in_scores[SCORE_W-1:0];
            tk_id_q    <= tk_id_q + ID_W'(1);
          end else begin
            beat_cnt   <= beat_cnt + BW'(1);
            tk_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        DONE: begin
          if (done_cnt == DW'(DONE_CYCLES - 1)) begin
            tk_done_q <= 1'b0;
            state     <= IDLE;
          end else begin
            done_cnt <= done_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = rdy;
  assign bus.tk_valid = tk_valid_q;
  assign bus.tk_score = tk_score_q;
  assign bus.tk_id    = tk_id_q;
  assign bus.tk_done  = tk_done_q;
  assign bus.busy     = (beat_cnt != '0) || (state != IDLE);

endmodule

// File: tb/tb_topk_feeder.sv
// tb_topk_feeder: directed/random bench for topk_feeder with a
// queue-based output model and a behavioural top-k selector.
module tb_topk_feeder;

  localparam int NE = 128;
  localparam int LANES = 16;
  localparam int SW = 16;
  localparam int IW = 7;
  localparam int DC = 8;
  localparam int BEATS = NE / LANES;

  typedef struct {
    bit valid;
    bit done;
    int id;
    int score;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  topk_feeder_if #(.LANES(LANES), .SCORE_W(SW), .ID_W(IW)) bus ();

  topk_feeder #(
    .NUM_EXPERTS(NE), .LANES(LANES), .SCORE_W(SW),
    .ID_W(IW), .DONE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model state
  ent_t q[$];
  bit   cur_valid = 0;
  bit   cur_done  = 0;
  int   exp_id    = 0;
  int   exp_score = 0;
  int   beats_done = 0;

  int   tok[NE];

  // selector model
  bit   sel_on = 0;
  ent_t sel_in[$];
  int   sel_ids[DC];
  int   sel_scr[DC];
  int   sel_rank = 0;
  int   sel_prev = 0;
  int   pid[DC];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES*SW-1:0] make_vec(input int b);
    logic [LANES*SW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++)
      v[i*SW +: SW] = SW'(tok[b*LANES + i]);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    cur_valid  = 0;
    cur_done   = 0;
    exp_id     = 0;
    exp_score  = 0;
    beats_done = 0;
  endtask

  task automatic sel_pick();
    int best;
    int bid;
    best = -1;
    bid  = -1;
    foreach (sel_in[i])
      if (sel_in[i].score < sel_prev && sel_in[i].score > best) begin
        best = sel_in[i].score;
        bid  = sel_in[i].id;
      end
    if (sel_rank < DC) begin
      sel_ids[sel_rank] = bid;
      sel_scr[sel_rank] = best;
    end
    sel_prev = best;
    sel_rank++;
  endtask

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic step(input logic v,
                      input logic [LANES*SW-1:0] d,
                      output bit acc);
    bit   rdy;
    ent_t e;
    bus.in_valid  = v;
    bus.in_scores = d;
    rdy = (q.size() == 0) && !cur_done;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
    @(posedge clk);
    acc = v && rdy;
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        e.valid = 1; e.done = 0;
        e.id    = beats_done * LANES + i;
        e.score = int'(d[i*SW +: SW]);
        q.push_back(e);
      end
      beats_done++;
      if (beats_done == BEATS) begin
        beats_done = 0;
        for (int i = 0; i < DC; i++) begin
          e.valid = 0; e.done = 1; e.id = 0; e.score = 0;
          q.push_back(e);
        end
      end
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      cur_valid = e.valid;
      cur_done  = e.done;
      if (e.valid) begin
        exp_id    = e.id;
        exp_score = e.score;
      end
    end else begin
      cur_valid = 0;
      cur_done  = 0;
    end
    #1;
    chk("tk_valid", {31'd0, bus.tk_valid}, {31'd0, cur_valid});
    chk("tk_done", {31'd0, bus.tk_done}, {31'd0, cur_done});
    chk("tk_id", 32'(bus.tk_id), 32'(exp_id));
    chk("tk_score", 32'(bus.tk_score), 32'(exp_score));
    chk("busy", {31'd0, bus.busy},
        {31'd0, cur_valid || cur_done || beats_done != 0});
    if (sel_on && bus.tk_valid) begin
      e.valid = 1; e.done = 0;
      e.id = int'(bus.tk_id); e.score = int'(bus.tk_score);
      sel_in.push_back(e);
    end
    if (sel_on && bus.tk_done) sel_pick();
  endtask

  task automatic feed_token(input int gap_beat, input int gap_len);
    bit acc;
    int n;
    for (int b = 0; b < BEATS; b++) begin
      acc = 0;
      n = 0;
      while (!acc && n <= 60) begin
        step(1'b1, make_vec(b), acc);
        n++;
      end
      chk("accept_timeout", {31'd0, acc}, 32'd1);
      if (!acc) return;
      if (b == gap_beat)
        for (int g = 0; g < gap_len; g++) step(1'b0, '0, acc);
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((cur_valid || cur_done || q.size() != 0) && n < 300) begin
      step(1'b0, '0, acc);
      n++;
    end
    chk("drain_timeout", {31'd0, n < 300}, 32'd1);
    step(1'b0, '0, acc);
  endtask

  initial begin : main
    bit acc;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_scores = '0;

    // 1: reset values, then ready/idle after release
    #1;
    chk("rst_tk_valid", {31'd0, bus.tk_valid}, 32'd0);
    chk("rst_tk_done", {31'd0, bus.tk_done}, 32'd0);
    chk("rst_tk_id", 32'(bus.tk_id), 32'd0);
    chk("rst_tk_score", 32'(bus.tk_score), 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    step(1'b0, '0, acc);
    step(1'b0, '0, acc);

    // 2: one token score = 3*id, back-to-back beats
    for (int i = 0; i < NE; i++) tok[i] = 3 * i;
    feed_token(-1, 0);

    // 4: next token offered during DONE, held until first IDLE
    for (int i = 0; i < NE; i++) tok[i] = 3 * i;
    feed_token(-1, 0);
    drain();

    // 3: 5-cycle input gap after the second beat
    for (int i = 0; i < NE; i++) tok[i] = $urandom_range(0, 65535);
    feed_token(1, 5);
    drain();

    // 5: reset while emitting id 55
    for (int i = 0; i < NE; i++) tok[i] = $urandom_range(0, 65535);
    for (int b = 0; b < 4; b++) begin
      acc = 0;
      n = 0;
      while (!acc && n <= 60) begin
        step(1'b1, make_vec(b), acc);
        n++;
      end
    end
    n = 0;
    while (!(cur_valid && exp_id == 55) && n < 40) begin
      step(1'b0, '0, acc);
      n++;
    end
    chk("reach_id55", 32'(exp_id), 32'd55);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tk_valid", {31'd0, bus.tk_valid}, 32'd0);
    chk("mid_rst_tk_done", {31'd0, bus.tk_done}, 32'd0);
    chk("mid_rst_tk_id", 32'(bus.tk_id), 32'd0);
    chk("mid_rst_tk_score", 32'(bus.tk_score), 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NE; i++) tok[i] = $urandom_range(0, 65535);
    feed_token(-1, 0);
    drain();

    // 6: random background with 8 planted maxima through selector
    for (int i = 0; i < NE; i++) tok[i] = $urandom_range(0, 999);
    for (int r = 0; r < DC; r++) begin
      pid[r] = r * LANES + $urandom_range(0, LANES - 1);
      tok[pid[r]] = 60000 + (DC - 1 - r) * 100;
    end
    sel_in.delete();
    sel_rank = 0;
    sel_prev = 1 << 20;
    sel_on = 1;
    feed_token($urandom_range(0, BEATS - 2), $urandom_range(1, 4));
    drain();
    sel_on = 0;
    chk("sel_done_cycles", 32'(sel_rank), 32'(DC));
    chk("sel_inputs", 32'(sel_in.size()), 32'(NE));
    for (int r = 0; r < DC; r++) begin
      chk("sel_id", 32'(sel_ids[r]), 32'(pid[r]));
      chk("sel_score", 32'(sel_scr[r]),
          32'(60000 + (DC - 1 - r) * 100));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
